// File: rtl/evg_heartbeat_sequencer.sv
// Heartbeat / sequence-start generator phase-locked to an asynchronous fiducial.
// All logic runs on evgTxClk; fiducial_a is the only asynchronous input.
module evg_heartbeat_sequencer #(
    parameter int TOLERANCE      = 2,
    parameter int INTERVAL_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 8
) (
    input  logic                      evgTxClk,
    input  logic                      evgReset,
    input  logic                      evgEnable,
    input  logic [INTERVAL_WIDTH-1:0] evgHeartbeatInterval,
    input  logic [DIVISOR_WIDTH-1:0]  evgSequenceDivisor,
    input  logic                      fiducial_a,
    output logic                      evgHeartbeatRequest,
    output logic                      evgSequenceStart,
    output logic                      evgLocked,
    output logic [15:0]               evgFiducialErrorCount,
    output logic [INTERVAL_WIDTH-1:0] evgMeasuredInterval
);
    localparam int SYNC_STAGES = 3;
    localparam logic [INTERVAL_WIDTH-1:0] ONE          = INTERVAL_WIDTH'(1);
    localparam logic [INTERVAL_WIDTH-1:0] MIN_INTERVAL = INTERVAL_WIDTH'(4);
    localparam logic [INTERVAL_WIDTH-1:0] TOL          = INTERVAL_WIDTH'(TOLERANCE);
    localparam logic [DIVISOR_WIDTH-1:0]  DONE         = DIVISOR_WIDTH'(1);

    typedef enum logic {HUNT, LOCKED} state_t;
    state_t state, stateNext;

    // [SYNC_STAGES-1:0] is the synchronizer, the top bit is edge-detect history
    logic [SYNC_STAGES:0]      fidPipe;
    logic                      fidPulse;
    logic [INTERVAL_WIDTH-1:0] periodCnt, measured;
    logic                      periodValid;

    logic [INTERVAL_WIDTH-1:0] nEff, nCfg, nCfgNext, phase, phaseNext, phaseDist;
    logic [DIVISOR_WIDTH-1:0]  dCfg, dCfgNext, seqCnt, seqCntNext;
    logic                      suppress, fidError, sample;
    logic                      hbReg, seqReg, hbNext, seqStartNext;
    logic [15:0]               errCount;

    assign nEff      = (evgHeartbeatInterval < MIN_INTERVAL) ? MIN_INTERVAL : evgHeartbeatInterval;
    assign phaseDist = nCfg - ONE - phase;

    // Fiducial synchronizer, edge detect and period measurement (enable-independent)
    always_ff @(posedge evgTxClk) begin
        if (evgReset) begin
            fidPipe     <= '0;
            fidPulse    <= 1'b0;
            periodCnt   <= '0;
            periodValid <= 1'b0;
            measured    <= '0;
        end else begin
            fidPipe  <= {fidPipe[SYNC_STAGES-1:0], fiducial_a};
            fidPulse <= fidPipe[SYNC_STAGES-1] & ~fidPipe[SYNC_STAGES];
            if (fidPulse) begin
                periodCnt   <= ONE;
                periodValid <= 1'b1;
                if (periodValid) measured <= periodCnt;
            end else if (periodCnt != '1) begin
                periodCnt <= periodCnt + ONE;
            end
        end
    end

    always_ff @(posedge evgTxClk) begin
        if (evgReset) begin
            state    <= HUNT;
            phase    <= '0;
            seqCnt   <= '0;
            nCfg     <= '0;
            dCfg     <= '0;
            hbReg    <= 1'b0;
            seqReg   <= 1'b0;
            errCount <= '0;
        end else begin
            state  <= stateNext;
            phase  <= phaseNext;
            seqCnt <= seqCntNext;
            nCfg   <= nCfgNext;
            dCfg   <= dCfgNext;
            hbReg  <= hbNext;
            seqReg <= seqStartNext;
            if (fidError && errCount != 16'hFFFF) errCount <= errCount + 16'd1;
        end
    end

    always_comb begin
        stateNext  = state;
        phaseNext  = phase;
        seqCntNext = seqCnt;
        suppress   = 1'b0;
        fidError   = 1'b0;
        if (!evgEnable) begin
            stateNext  = HUNT;
            phaseNext  = '0;
            seqCntNext = '0;
        end else begin
            case (state)
                HUNT: begin
                    if (fidPulse) begin
                        stateNext  = LOCKED;
                        phaseNext  = '0;
                        seqCntNext = '0;
                    end
                end
                LOCKED: begin
                    if (hbReg)
                        seqCntNext = (dCfg == '0 || seqCnt >= dCfg - DONE) ? '0 : seqCnt + DONE;
                    phaseNext = (phase >= nCfg - ONE) ? '0 : phase + ONE;
                    if (fidPulse && phaseDist != '0) begin
                        if (phaseDist <= TOL) begin
                            phaseNext = '0;
                        end else if (phase < TOL) begin
                            // late: restart the cadence but swallow this heartbeat
                            phaseNext = '0;
                            suppress  = 1'b1;
                        end else begin
                            fidError   = 1'b1;
                            stateNext  = HUNT;
                            phaseNext  = '0;
                            seqCntNext = '0;
                        end
                    end
                end
                default: stateNext = HUNT;
            endcase
        end
        sample   = (stateNext == LOCKED) && (phaseNext == '0);
        nCfgNext = sample ? nEff : nCfg;
        dCfgNext = sample ? evgSequenceDivisor : dCfg;
    end

    always_comb begin
        hbNext       = (stateNext == LOCKED) && (phaseNext == '0) && !suppress;
        seqStartNext = hbNext && (seqCntNext == '0) && (dCfgNext != '0);
    end

    assign evgHeartbeatRequest   = hbReg;
    assign evgSequenceStart      = seqReg;
    assign evgLocked             = (state == LOCKED);
    assign evgFiducialErrorCount = errCount;
    assign evgMeasuredInterval   = measured;
endmodule

// File: tb/tb_evg_heartbeat_sequencer.sv
// Bench for evg_heartbeat_sequencer: directed and random fiducial traffic
// checked every cycle against an absolute-time reference model.
module tb_evg_heartbeat_sequencer;
    localparam int TOL = 2;

    logic        evgTxClk = 1'b0;
    logic        evgReset;
    logic        evgEnable;
    logic [31:0] evgHeartbeatInterval;
    logic [7:0]  evgSequenceDivisor;
    logic        fiducial_a;
    logic        evgHeartbeatRequest;
    logic        evgSequenceStart;
    logic        evgLocked;
    logic [15:0] evgFiducialErrorCount;
    logic [31:0] evgMeasuredInterval;

    int checks = 0;
    int errors = 0;
    int errFloor = 0;

    always #5 evgTxClk = ~evgTxClk;

    evg_heartbeat_sequencer dut (
        .evgTxClk              (evgTxClk),
        .evgReset              (evgReset),
        .evgEnable             (evgEnable),
        .evgHeartbeatInterval  (evgHeartbeatInterval),
        .evgSequenceDivisor    (evgSequenceDivisor),
        .fiducial_a            (fiducial_a),
        .evgHeartbeatRequest   (evgHeartbeatRequest),
        .evgSequenceStart      (evgSequenceStart),
        .evgLocked             (evgLocked),
        .evgFiducialErrorCount (evgFiducialErrorCount),
        .evgMeasuredInterval   (evgMeasuredInterval)
    );

    // Reference model: cadence expressed as an anchor cycle plus heartbeat count
    int          cyc = 0;
    bit          mInit = 0, mLocked = 0, mValid = 0, expHb = 0, expSeq = 0, fidPrev;
    int          anchor = 0, neff = 4, dDiv = 0, supCyc = -1, hbCnt = 0, errRaw = 0, lastFid = 0, p;
    int unsigned mMeas = 0;
    bit [4:0]    hist = '0;
    int          expErr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    always @(posedge evgTxClk) begin
        cyc++;
        fidPrev = hist[3] & ~hist[4];
        hist = {hist[3:0], fiducial_a};
        if (evgReset) begin
            mInit = 1; mLocked = 0; mValid = 0; mMeas = 0; hbCnt = 0; errRaw = 0;
            supCyc = -1; hist = '0;
        end else if (mInit) begin
            if (fidPrev) begin
                if (mValid) mMeas = cyc - 1 - lastFid;
                lastFid = cyc - 1;
                mValid = 1;
            end
            if (expHb) hbCnt++;
            if (!evgEnable) begin
                mLocked = 0;
            end else if (fidPrev) begin
                if (!mLocked) begin
                    mLocked = 1;
                    anchor  = cyc;
                    neff    = (evgHeartbeatInterval < 4) ? 4 : int'(evgHeartbeatInterval);
                    dDiv    = int'(evgSequenceDivisor);
                    hbCnt   = 0;
                    supCyc  = -1;
                end else begin
                    p = (cyc - 1 - anchor) % neff;
                    if (neff - 1 - p != 0) begin
                        if (neff - 1 - p <= TOL) anchor = cyc;
                        else if (p < TOL) begin anchor = cyc; supCyc = cyc; end
                        else begin mLocked = 0; errRaw++; end
                    end
                end
            end
        end
        expHb  = mLocked && ((cyc - anchor) % neff == 0) && (cyc != supCyc);
        expSeq = expHb && dDiv != 0 && (hbCnt % dDiv == 0);
        expErr = (errFloor + errRaw > 65535) ? 65535 : errFloor + errRaw;
        #1;
        if (mInit) begin
            chk("heartbeat", 32'(evgHeartbeatRequest), 32'(expHb));
            chk("seqstart",  32'(evgSequenceStart),    32'(expSeq));
            chk("locked",    32'(evgLocked),           32'(mLocked));
            chk("errcount",  32'(evgFiducialErrorCount), 32'(expErr));
            chk("measured",  evgMeasuredInterval,      mMeas);
        end
    end

    // Raise fiducial for h cycles; the next call raises exactly d cycles later
    task automatic fidGap(input int h, input int d);
        fiducial_a = 1'b1;
        repeat (h) @(negedge evgTxClk);
        fiducial_a = 1'b0;
        repeat (d - h) @(negedge evgTxClk);
    endtask

    task automatic reconfig(input int n, input int d);
        evgEnable = 1'b0;
        evgHeartbeatInterval = 32'(n);
        evgSequenceDivisor = 8'(d);
        repeat (2) @(negedge evgTxClk);
        evgEnable = 1'b1;
        @(negedge evgTxClk);
    endtask

    task automatic enableDropOnFid();
        fiducial_a = 1'b1;
        repeat (4) @(negedge evgTxClk);
        evgEnable = 1'b0;
        @(negedge evgTxClk);
        evgEnable = 1'b1;
        fiducial_a = 1'b0;
        repeat (20) @(negedge evgTxClk);
    endtask

    initial begin
        int n, gap;
        evgReset = 1'b1; evgEnable = 1'b0; fiducial_a = 1'b0;
        evgHeartbeatInterval = 32'd10; evgSequenceDivisor = 8'd3;
        repeat (3) @(negedge evgTxClk);
        evgReset = 1'b0; evgEnable = 1'b1;
        repeat (3) @(negedge evgTxClk);

        // lock, exact, early by 1, late by 2, out of tolerance, relock
        fidGap(2, 10); fidGap(2, 9); fidGap(2, 22); fidGap(2, 16); fidGap(2, 30); fidGap(2, 40);

        reconfig(0, 2); fidGap(2, 30);
        reconfig(5, 0); fidGap(2, 30);

        reconfig(10, 3); enableDropOnFid();
        reconfig(10, 3); fidGap(2, 13); enableDropOnFid();

        force dut.errCount = 16'hFFFF;
        errFloor = 65535;
        repeat (2) @(negedge evgTxClk);
        release dut.errCount;
        repeat (2) @(negedge evgTxClk);
        reconfig(10, 3); fidGap(2, 13); fidGap(2, 20);

        reconfig(7, 2); fidGap(2, 15);
        evgReset = 1'b1; errFloor = 0;
        @(negedge evgTxClk);
        evgReset = 1'b0;
        repeat (5) @(negedge evgTxClk);

        evgEnable = 1'b0;
        fidGap(20, 1000); fidGap(20, 1000); fidGap(20, 1000);

        for (int it = 0; it < 10; it++) begin
            n = int'($urandom_range(6, 20));
            reconfig(n, int'($urandom_range(0, 4)));
            for (int j = 0; j < 7; j++) begin
                gap = n * int'($urandom_range(1, 3)) + int'($urandom_range(0, 8)) - 4;
                fidGap(1, gap);
            end
        end

        repeat (10) @(negedge evgTxClk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/evg_heartbeat_sequencer.md
Name: evg_heartbeat_sequencer

Overview:
- Generates `evgHeartbeatRequest` and `evgSequenceStart`, the two timing inputs of the event generator.
- Runs entirely in the transmit clock domain.
- Locks a programmable heartbeat cadence to an external asynchronous fiducial, such as the machine coincidence or PPS marker.
- Reports lock state, phase errors and the measured fiducial period back to system software.

Parameters:
- TOLERANCE, 2, maximum phase slip in clocks (early or late) that is absorbed by realignment without counting an error.
- INTERVAL_WIDTH, 32, width of the heartbeat interval and measured period.
- DIVISOR_WIDTH, 8, width of the sequence divisor.

Ports:
- evgTxClk  in  1  transmit clock; all logic runs on it.
- evgReset  in  1  synchronous, active-high reset.
- evgEnable  in  1  run enable; low forces HUNT and quiet outputs.
- evgHeartbeatInterval  in  INTERVAL_WIDTH  N, clocks between heartbeats; quasi-static.
- evgSequenceDivisor  in  DIVISOR_WIDTH  D, heartbeats per sequence start; 0 disables sequence starts.
- fiducial_a  in  1  asynchronous fiducial marker; rising edge is significant.
- evgHeartbeatRequest  out  1  one-clock heartbeat pulse.
- evgSequenceStart  out  1  one-clock pulse, always coincident with a heartbeat.
- evgLocked  out  1  high while in LOCKED state.
- evgFiducialErrorCount  out  16  count of out-of-tolerance fiducials; saturating.
- evgMeasuredInterval  out  INTERVAL_WIDTH  clocks between the last two fiducials.

Behaviour:
- Reset:
  - All outputs 0; state HUNT.
  - Phase counter P = 0, sequence counter S = 0.
  - The measured-period valid flag is cleared.
- Fiducial input path:
  - `fiducial_a` passes through a 3-flop synchronizer, then a rising-edge detect, producing fidPulse.
  - fidPulse asserts exactly 3 clocks after the first flop samples high.
  - A high level held for many cycles yields a single fidPulse.
- Period measurement (runs in every state, independent of `evgEnable`):
  - Counter C increments each clock and saturates at all-ones.
  - On fidPulse, C loads 1.
  - On fidPulse with valid set, `evgMeasuredInterval` <= C; the valid flag is then set.
  - The first fidPulse after reset therefore updates only the flag, not `evgMeasuredInterval`.
- Configuration sampling:
  - Neff = max(`evgHeartbeatInterval`, 4).
  - N and D are sampled on entry to LOCKED and whenever P wraps.
- State HUNT:
  - Outputs 0; `evgLocked` = 0.
  - On fidPulse with `evgEnable` = 1: go to LOCKED with P_next = 0 and S_next = 0.
  - Therefore the first heartbeat and the first sequence start both occur at fidPulse cycle + 1.
- State LOCKED:
  - `evgLocked` = 1.
  - P counts 0..Neff-1, then wraps to 0.
  - `evgHeartbeatRequest` = 1 exactly in cycles with P == 0.
  - On each heartbeat, S advances modulo D.
  - `evgSequenceStart` = 1 when P == 0, S == 0 and D != 0.
  - Both outputs are register-driven, with no combinational path from inputs.
- Fiducial phase check in LOCKED (evaluated on fidPulse):
  - Exact: P == Neff-1. No action.
  - Early by k (P == Neff-1-k, 1 <= k <= TOLERANCE): P_next = 0, so a heartbeat occurs at the fiducial cycle + 1. S advances normally.
  - Late by k (P == k-1, 1 <= k <= TOLERANCE): P_next = 0 with the heartbeat suppressed for that one cycle, and S does not advance. This prevents a double heartbeat.
  - Any other P: out of tolerance. `evgFiducialErrorCount` increments (saturating at 0xFFFF), state goes to HUNT, and outputs go quiet until the next fidPulse relocks.
  - Fiducials are allowed to be sparse (e.g. one per many heartbeats). A missing fiducial is not an error.
- `evgEnable` low:
  - Next cycle: state HUNT, P = S = 0, pulses 0.
  - The error counter and measured period are preserved.
  - If fidPulse and the falling edge of `evgEnable` occur in the same cycle, enable wins: no lock, no error count.
- Reset mid-operation:
  - Takes effect at the next edge; no pulse is emitted in the cycle after reset is asserted.
  - `evgFiducialErrorCount` clears only on reset.

Test Plan:
- Lock: N=10, D=3, enable=1, fidPulse at cycle t.
  - Heartbeats at t+1, t+11, t+21, t+31.
  - Sequence starts at t+1 and t+31 only.
  - `evgLocked` rises at t+1.
- Exact and early: locked as above; fiducial with fidPulse at t+10, then one at t+19 (early by 1).
  - No change at t+10.
  - Heartbeat at t+20 (not t+21); next heartbeat at t+30.
  - Error count stays 0.
- Late and error:
  - fidPulse at P==1 (late by 2): no heartbeat that cycle, next heartbeat N cycles later, S unchanged.
  - fidPulse at P==5: error count 1, `evgLocked` 0, no heartbeats until the next fidPulse relocks.
- Measurement: fiducial_a pulses (held 20 clocks) spaced 1000 clocks apart.
  - fidPulse appears 3 clocks after the first flop samples high.
  - Exactly one fidPulse per pulse.
  - `evgMeasuredInterval` = 1000 after the second fiducial; unchanged after the first.
- Boundaries:
  - N=0: cadence of 4 clocks.
  - D=0: heartbeats with no sequence starts.
  - Error count forced to 0xFFFF plus one further error: stays 0xFFFF.
  - `evgEnable` drop in the same cycle as fidPulse: no lock, no error count.
  - Reset mid-lock: all outputs 0 next cycle.
